dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Multi-cycle sequencer between the MEM stage of the RV32I pipeline and a variable-latency data-memory bus. It takes the decoded load/store controls for the instruction in MEM: read, write, width mode, and unsigned flag. From these it generates a word-aligned bus request with byte enables, and it stalls the pipeline until the access completes. Load data is returned lane-extracted and sign- or zero-extended; misaligned accesses and bus timeouts are reported as a fault.

## Interface
- `ADDR_WIDTH`, 32, byte-address width
- `TIMEOUT`, 255, maximum cycles spent in REQ+WAIT before a forced fault completion (1..255)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mem_read_i`  in  1  MEM-stage load
- `mem_write_i`  in  1  MEM-stage store
- `mem_mode_i`  in  `MEMORY_MODE_WIDTH`  `BYTE_`/`HALFWORD_`/`WORD_MEMORY_MODE`
- `mem_unsigned_i`  in  1  funct3[2]; 1 = zero-extend load (LBU/LHU)
- `addr_i`  in  ADDR_WIDTH  ALU-computed byte address
- `wdata_i`  in  32  rs2 value for stores
- `rdata_o`  out  32  extended load data, valid in DONE, held afterwards
- `stall_o`  out  1  freeze IF..MEM
- `fault_o`  out  1  1-cycle pulse in DONE: misaligned or timeout
- `fault_addr_o`  out  ADDR_WIDTH  address of the faulting access, held
- `bus_req_o`  out  1  request
- `bus_we_o`  out  1  1 = write
- `bus_addr_o`  out  ADDR_WIDTH  address with [1:0] = 0
- `bus_be_o`  out  4  byte enables
- `bus_wdata_o`  out  32  lane-replicated store data
- `bus_gnt_i`  in  1  request accepted
- `bus_rvalid_i`  in  1  response (read data or write ack)
- `bus_rdata_i`  in  32  read word

## Operation
- An access is active when `mem_read_i | mem_write_i`. If both are set, the access is treated as a write.
- Misalignment rules:
  - halfword is misaligned when `addr_i[0]` = 1
  - word is misaligned when `addr_i[1:0]` ≠ 0
  - byte is never misaligned
- FSM states:
  - IDLE
    - No access: stay in IDLE.
    - Aligned access: capture we, aligned address, be, wdata, lane, mode and unsigned into registers, clear the counter, go to REQ.
    - Misaligned access: latch `fault_addr_o`, set a fault flag, go to DONE with no bus activity.
  - REQ: `bus_req_o` = 1. On `bus_gnt_i`, go to WAIT.
  - WAIT: on `bus_rvalid_i`, capture the load result (reads only) and go to DONE.
  - Timeout: in REQ or WAIT, if the counter reaches `TIMEOUT`, go to DONE with the fault flag set, `rdata_o` = 0 and `fault_addr_o` latched.
  - DONE: `fault_o` = fault flag. Go to IDLE unconditionally.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'b1111`
- Write data:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: as-is
- Load extraction selects the lane by the captured addr[1:0]. Byte or halfword results are sign-extended unless unsigned, in which case they are zero-extended. Word results pass through.
- Counter: 8 bits, increments every cycle in REQ or WAIT, saturates.
- `bus_gnt_i` outside REQ and `bus_rvalid_i` outside WAIT are ignored; stray responses must not change state.
- Bus outputs are registered and stable throughout REQ. `bus_addr_o`/`bus_be_o`/`bus_wdata_o`/`bus_we_o` hold their values in WAIT.

## Timing
- Reset (async assert, sync deassert by the environment):
  - state = IDLE
  - `bus_req_o`, `bus_we_o`, `bus_be_o`, `bus_addr_o`, `bus_wdata_o` = 0
  - `rdata_o` = 0, `fault_o` = 0, `fault_addr_o` = 0, counter = 0
- `stall_o` is combinational:
  - 1 in IDLE with an active access
  - 1 in REQ and WAIT
  - 0 in DONE, which lets the pipeline advance at the end of DONE
- Minimum aligned access (gnt in the first REQ cycle, rvalid in the first WAIT cycle): IDLE, REQ, WAIT, DONE. That is 3 stall cycles, with the instruction leaving MEM at the end of cycle 4.
- Misaligned access: IDLE, DONE. 1 stall cycle, `fault_o` pulses in cycle 2.
- `rvalid` may not be counted in the same cycle as `gnt`. The earliest counted response is the cycle after gnt.
- The cycle after DONE is IDLE and evaluates the next MEM instruction. Back-to-back accesses therefore cost 4 cycles each at minimum.
- Reset mid-access: state forced to IDLE and `bus_req_o` dropped immediately. Any later `rvalid` is ignored.

## Test plan
- LW addr 0x100, gnt at +0, rvalid with 0xDEADBEEF at +1:
  - `bus_addr_o`=0x100, be=1111
  - `stall_o` high for 3 cycles
  - `rdata_o`=0xDEADBEEF in DONE, `fault_o`=0
- LB addr 0x203 and LBU addr 0x203, read word 0x80112233:
  - be=1000
  - `rdata_o` = 0xFFFFFF80 (LB) and 0x00000080 (LBU)
- SH addr 0x302, wdata 0x0000ABCD: `bus_we_o`=1, be=1100, `bus_wdata_o`=0xABCDABCD, `bus_addr_o`=0x300; the write ack ends the stall.
- LW addr 0x101:
  - no `bus_req_o`
  - `stall_o` for exactly 1 cycle
  - `fault_o` pulse, `fault_addr_o`=0x101
- `TIMEOUT`=4, gnt never asserted: `bus_req_o` held for 4 cycles, then DONE with `fault_o`=1, `rdata_o`=0, return to IDLE.
- Assert `rst_n`=0 while in WAIT, then deliver a late `rvalid`: outputs are at reset values immediately, and no state change or data capture occurs after release.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequencer between the MEM stage and a variable-latency
// data-memory bus. It turns one load/store into a word-aligned bus request
// with byte enables and stalls the pipeline until the bus responds. Loads
// come back lane-extracted and sign/zero-extended. Misaligned accesses and
// bus timeouts complete with a fault pulse.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   mem_read_i/mem_write_i     MEM-stage load/store (both set => store)
//   mem_mode_i, mem_unsigned_i access width, zero-extend select
//   addr_i, wdata_i            byte address, store data
//   rdata_o                    extended load data (valid in DONE, held)
//   stall_o                    freeze IF..MEM
//   fault_o, fault_addr_o      1-cycle fault pulse in DONE, faulting address
//   bus_*                      req/gnt, rvalid/rdata bus handshake
module dmem_access_ctrl #(
  parameter int ADDR_WIDTH        = 32,
  parameter int TIMEOUT           = 255,
  parameter int MEMORY_MODE_WIDTH = 2,
  parameter logic [MEMORY_MODE_WIDTH-1:0] BYTE_MEMORY_MODE     = MEMORY_MODE_WIDTH'(0),
  parameter logic [MEMORY_MODE_WIDTH-1:0] HALFWORD_MEMORY_MODE = MEMORY_MODE_WIDTH'(1),
  parameter logic [MEMORY_MODE_WIDTH-1:0] WORD_MEMORY_MODE     = MEMORY_MODE_WIDTH'(2)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mem_read_i,
  input  logic                         mem_write_i,
  input  logic [MEMORY_MODE_WIDTH-1:0] mem_mode_i,
  input  logic                         mem_unsigned_i,
  input  logic [ADDR_WIDTH-1:0]        addr_i,
  input  logic [31:0]                  wdata_i,
  output logic [31:0]                  rdata_o,
  output logic                         stall_o,
  output logic                         fault_o,
  output logic [ADDR_WIDTH-1:0]        fault_addr_o,
  output logic                         bus_req_o,
  output logic                         bus_we_o,
  output logic [ADDR_WIDTH-1:0]        bus_addr_o,
  output logic [3:0]                   bus_be_o,
  output logic [31:0]                  bus_wdata_o,
  input  logic                         bus_gnt_i,
  input  logic                         bus_rvalid_i,
  input  logic [31:0]                  bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                       state, state_n;
  logic [7:0]                   cnt;
  logic                         fault_q;
  logic [1:0]                   lane_q;
  logic [MEMORY_MODE_WIDTH-1:0] mode_q;
  logic                         uns_q;

  logic        active, is_byte, is_half, is_word, misal;
  logic        timeout_hit, timeout_fire;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, lane_word, load_ext;

  assign active  = mem_read_i | mem_write_i;
  assign is_byte = (mem_mode_i == BYTE_MEMORY_MODE);
  assign is_half = (mem_mode_i == HALFWORD_MEMORY_MODE);
  // any encoding that is not byte/half is handled as a full word
  assign is_word = ~is_byte & ~is_half;
  assign misal   = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = wdata_i;
    if (is_byte) begin
      be_n    = 4'b0001 << addr_i[1:0];
      wdata_n = {4{wdata_i[7:0]}};
    end else if (is_half) begin
      be_n    = 4'b0011 << {addr_i[1], 1'b0};
      wdata_n = {2{wdata_i[15:0]}};
    end
  end

  // halfword lanes are always even, so one shift serves every width
  assign lane_word = bus_rdata_i >> {lane_q, 3'b000};

  always_comb begin
    load_ext = lane_word;
    if (mode_q == BYTE_MEMORY_MODE)
      load_ext = {{24{~uns_q & lane_word[7]}}, lane_word[7:0]};
    else if (mode_q == HALFWORD_MEMORY_MODE)
      load_ext = {{16{~uns_q & lane_word[15]}}, lane_word[15:0]};
  end

  // cnt holds the number of REQ/WAIT cycles already spent, so the hit marks
  // the TIMEOUT-th cycle. A response arriving in that very cycle still wins.
  assign timeout_hit  = (cnt >= 8'(TIMEOUT - 1));
  assign timeout_fire = timeout_hit &
                        ((state == REQ) | ((state == WAIT) & ~bus_rvalid_i));

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (active) state_n = misal ? DONE : REQ;
      REQ:  if (timeout_fire) state_n = DONE;
            else if (bus_gnt_i) state_n = WAIT;
      WAIT: if (bus_rvalid_i | timeout_fire) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign stall_o = ((state == IDLE) & active) | (state == REQ) | (state == WAIT);
  assign fault_o = (state == DONE) & fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      fault_q      <= 1'b0;
      lane_q       <= '0;
      mode_q       <= '0;
      uns_q        <= 1'b0;
      rdata_o      <= '0;
      fault_addr_o <= '0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= '0;
      bus_be_o     <= '0;
      bus_wdata_o  <= '0;
    end else begin
      state     <= state_n;
      bus_req_o <= (state_n == REQ);
      case (state)
        IDLE: if (active) begin
          if (misal) begin
            fault_q      <= 1'b1;
            fault_addr_o <= addr_i;
          end else begin
            fault_q     <= 1'b0;
            cnt         <= '0;
            bus_we_o    <= mem_write_i;
            bus_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            bus_be_o    <= be_n;
            bus_wdata_o <= wdata_n;
            lane_q      <= addr_i[1:0];
            mode_q      <= mem_mode_i;
            uns_q       <= mem_unsigned_i;
          end
        end
        REQ, WAIT: begin
          if (cnt != 8'hFF) cnt <= cnt + 8'd1;
          if (timeout_fire) begin
            fault_q      <= 1'b1;
            rdata_o      <= '0;
            fault_addr_o <= {bus_addr_o[ADDR_WIDTH-1:2], lane_q};
          end else if ((state == WAIT) & bus_rvalid_i & ~bus_we_o) begin
            rdata_o <= load_ext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus a randomized stream of
// loads/stores with random grant/response latency and stray bus strobes,
// each checked against a reference model of the access rules.
module tb_dmem_access_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read_i, mem_write_i, mem_unsigned_i;
  logic [1:0]  mem_mode_i;
  logic [31:0] addr_i, wdata_i, rdata_o, fault_addr_o;
  logic        stall_o, fault_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] m_rdata = 0, m_faddr = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_mode_i(mem_mode_i), .mem_unsigned_i(mem_unsigned_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .fault_o(fault_o),
    .fault_addr_o(fault_addr_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  function automatic logic [31:0] model_load(logic [31:0] w, int mode, bit uns, int off);
    longint s, v;
    s = longint'(w) / (longint'(1) << (8 * off));
    if (mode == 0) begin
      v = s % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (mode == 1) begin
      v = s % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end else v = s;
    return 32'(v);
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mem_read_i = 0; mem_write_i = 0;
      bus_gnt_i = 0; bus_rvalid_i = 0;
    end
  endtask

  // g: REQ cycles before gnt (gnt in REQ cycle g+1); r: WAIT cycle of rvalid
  task automatic do_access(input bit rd, input bit wr, input int mode, input bit uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int g, input int r, input logic [31:0] rword,
                           input string tag);
    int off, total, exp_stalls, exp_reqs, cyc, stalls, reqs, faults, rq, wc;
    bit misal, exp_to, exp_fault, granted, done;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_addr;
    off    = int'(a % 4);
    misal  = (mode == 1 && off % 2 == 1) || (mode == 2 && off != 0);
    exp_be = (mode == 0) ? 4'(1 << off) : (mode == 1) ? 4'(3 << (off / 2 * 2)) : 4'hF;
    exp_wd = (mode == 0) ? (wd % 256) * 32'h01010101 :
             (mode == 1) ? (wd % 65536) * 32'h00010001 : wd;
    exp_addr   = a - 32'(off);
    total      = g + 1 + r;
    exp_to     = !misal && total > TO;
    exp_fault  = misal || exp_to;
    exp_stalls = 1 + (misal ? 0 : (exp_to ? TO : total));
    exp_reqs   = misal ? 0 : ((g + 1 < TO) ? g + 1 : TO);
    if (exp_fault) m_faddr = a;
    if (exp_to) m_rdata = 0;
    else if (!misal && rd && !wr) m_rdata = model_load(rword, mode, uns, off);

    @(posedge clk); #1;
    mem_read_i = rd; mem_write_i = wr; mem_mode_i = 2'(mode);
    mem_unsigned_i = uns; addr_i = a; wdata_i = wd;
    cyc = 0; stalls = 0; reqs = 0; faults = 0; rq = 0; wc = 0;
    granted = 0; done = 0;
    while (!done && cyc < 300) begin
      // bus responder: reacts to bus_req_o, adds stray strobes where ignored
      bus_gnt_i = 0;
      bus_rvalid_i = ($urandom_range(0, 2) == 0);
      bus_rdata_i = $urandom;
      if (bus_req_o && !granted) begin
        rq++;
        if (rq == g + 1) begin bus_gnt_i = 1; granted = 1; end
      end else if (granted) begin
        wc++;
        bus_gnt_i = $urandom_range(0, 1);
        bus_rvalid_i = (wc == r);
        if (wc == r) bus_rdata_i = rword;
      end
      @(negedge clk);
      if (stall_o) stalls++;
      if (fault_o) faults++;
      if (bus_req_o) begin
        reqs++;
        compared++;
        if ({bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o} !== {wr, exp_addr, exp_be, exp_wd}) begin
          mismatched++;
          $display("FAIL %s bus_fields got we=%b addr=%h be=%b wd=%h want we=%b addr=%h be=%b wd=%h",
                   tag, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, wr, exp_addr, exp_be, exp_wd);
        end
      end
      if (!stall_o) done = 1;
      else begin @(posedge clk); #1; end
      cyc++;
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL %s completion got none within 300 cycles want DONE", tag);
    end
    compared++;
    if (stalls !== exp_stalls) begin
      mismatched++;
      $display("FAIL %s stall_cycles got %0d want %0d", tag, stalls, exp_stalls);
    end
    compared++;
    if (reqs !== exp_reqs) begin
      mismatched++;
      $display("FAIL %s req_cycles got %0d want %0d", tag, reqs, exp_reqs);
    end
    compared++;
    if (fault_o !== exp_fault || faults !== int'(exp_fault)) begin
      mismatched++;
      $display("FAIL %s fault got %b (pulses %0d) want %b", tag, fault_o, faults, exp_fault);
    end
    compared++;
    if (rdata_o !== m_rdata) begin
      mismatched++;
      $display("FAIL %s rdata got %h want %h", tag, rdata_o, m_rdata);
    end
    compared++;
    if (fault_addr_o !== m_faddr) begin
      mismatched++;
      $display("FAIL %s fault_addr got %h want %h", tag, fault_addr_o, m_faddr);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; mem_read_i = 0; mem_write_i = 0; mem_mode_i = 0; mem_unsigned_i = 0;
    addr_i = 0; wdata_i = 0; bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, rdata_o, fault_o,
         fault_addr_o, stall_o} !== '0) begin
      mismatched++;
      $display("FAIL reset_values got req=%b we=%b be=%b addr=%h wd=%h rd=%h f=%b fa=%h st=%b want all 0",
               bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, rdata_o, fault_o,
               fault_addr_o, stall_o);
    end
    rst_n = 1;
  endtask

  task automatic test_lw();
    do_access(1, 0, 2, 0, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, "lw_0x100");
  endtask

  task automatic test_lb_lbu();
    do_access(1, 0, 0, 0, 32'h203, 32'h0, 0, 1, 32'h80112233, "lb_0x203");
    compared++;
    if (rdata_o !== 32'hFFFFFF80) begin
      mismatched++;
      $display("FAIL lb_value got %h want ffffff80", rdata_o);
    end
    do_access(1, 0, 0, 1, 32'h203, 32'h0, 0, 1, 32'h80112233, "lbu_0x203");
    compared++;
    if (rdata_o !== 32'h00000080) begin
      mismatched++;
      $display("FAIL lbu_value got %h want 00000080", rdata_o);
    end
  endtask

  task automatic test_sh();
    do_access(0, 1, 1, 0, 32'h302, 32'h0000ABCD, 1, 2, 32'h0, "sh_0x302");
  endtask

  task automatic test_misaligned();
    do_access(1, 0, 2, 0, 32'h101, 32'h0, 0, 1, 32'h12345678, "lw_0x101");
    do_access(1, 0, 1, 0, 32'h203, 32'h0, 0, 1, 32'h12345678, "lh_0x203");
  endtask

  task automatic test_timeout();
    do_access(1, 0, 2, 0, 32'h400, 32'h0, 1000, 1, 32'h0, "timeout_nognt");
    do_access(1, 0, 2, 0, 32'h404, 32'h0, 0, 5, 32'h0, "timeout_wait");
    do_access(1, 0, 2, 0, 32'h408, 32'h0, 1, 2, 32'h5A5A5A5A, "rvalid_last_cycle");
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 3);
      do_access(k != 1, k == 1 || k == 2, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3), $urandom,
                "random");
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    mem_read_i = 1; mem_write_i = 0; mem_mode_i = 2; addr_i = 32'h500;
    bus_gnt_i = 0; bus_rvalid_i = 0;
    @(posedge clk); #1;                     // REQ
    bus_gnt_i = 1;
    @(posedge clk); #1;                     // WAIT
    bus_gnt_i = 0; mem_read_i = 0;
    #2 rst_n = 0;
    #1;
    compared++;
    if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, rdata_o, fault_o,
         fault_addr_o, stall_o} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid got req=%b be=%b addr=%h rd=%h st=%b want all 0",
               bus_req_o, bus_be_o, bus_addr_o, rdata_o, stall_o);
    end
    @(negedge clk); rst_n = 1;
    m_rdata = 0; m_faddr = 0;
    @(posedge clk); #1;
    bus_rvalid_i = 1; bus_rdata_i = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if ({bus_req_o, stall_o, fault_o, rdata_o} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
        mismatched++;
        $display("FAIL late_rvalid got req=%b st=%b f=%b rd=%h want 0 0 0 0",
                 bus_req_o, stall_o, fault_o, rdata_o);
      end
      @(posedge clk); #1;
      bus_rvalid_i = 0;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    do_access(1, 0, 2, 0, 32'h600, 32'h0, 0, 1, 32'h0BADF00D, "after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
